// File: rtl/ppwm_pkg.sv
// Shared constants for the programmable PWM channel bank.
//   Address map of the byte-wide config port, ctrl register bit positions,
//   and the reset value of the period register.
package ppwm_pkg;

   localparam logic [3:0] ADDR_PERIOD = 4'd8;
   localparam logic [3:0] ADDR_PRESC  = 4'd9;
   localparam logic [3:0] ADDR_CTRL   = 4'd10;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_COMMIT_BIT = 1;

   localparam logic [7:0] PERIOD_RST = 8'hFF;

endpackage

// File: rtl/ppwm_channel_bank_if.sv
// Config write port of the PWM channel bank.
//   cfg_we    write strobe, one write per cycle
//   cfg_addr  register address
//   cfg_data  write data
// master drives the port (pads / host), slave is the channel bank.
interface ppwm_channel_bank_if;

   logic       cfg_we;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_data;

   modport master (output cfg_we, cfg_addr, cfg_data);
   modport slave  (input  cfg_we, cfg_addr, cfg_data);

endinterface

// File: rtl/ppwm_prescaler.sv
// Shared prescaler for the PWM channel bank.
//   clk, rst_n  clock, synchronous active-low reset
//   en_i        count enable; when low the counter is held at 0
//   clr_i       force the counter back to 0 on the next edge
//   presc_i     terminal value; tick_o fires when the counter equals it
//   tick_o      combinational tick, one cycle every presc_i+1 enabled cycles
module ppwm_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [PRESC_W-1:0] presc_i,
   output logic               tick_o
);

   logic [PRESC_W-1:0] pcnt_q, pcnt_d;

   assign tick_o = en_i && (pcnt_q == presc_i);

   always_comb begin
      pcnt_d = pcnt_q + PRESC_W'(1);
      if (!en_i || clr_i || tick_o) begin
         pcnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/ppwm_channel_bank.sv
// Multi-channel programmable PWM generator.
//   Staging registers (duty[], period, presc, enable) are written through a
//   byte-wide config port. duty/period/presc are double-buffered: a commit
//   request copies them into the active set at the next period boundary (or
//   on the next cycle while disabled). Enable acts directly from staging.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   cfg          config write port (slave side)
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  one-cycle pulse the cycle after each period boundary
//   commit_busy  commit requested but not yet applied
module ppwm_channel_bank
   import ppwm_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int CNT_W   = 8,
   parameter int PRESC_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   ppwm_channel_bank_if.slave  cfg,
   output logic [NUM_CH-1:0]   pwm_out,
   output logic                period_tick,
   output logic                commit_busy
);

   logic [NUM_CH-1:0][CNT_W-1:0] duty_stg_q, duty_stg_d;
   logic [NUM_CH-1:0][CNT_W-1:0] duty_act_q, duty_act_d;
   logic [CNT_W-1:0]             period_stg_q, period_stg_d;
   logic [CNT_W-1:0]             period_act_q, period_act_d;
   logic [PRESC_W-1:0]           presc_stg_q, presc_stg_d;
   logic [PRESC_W-1:0]           presc_act_q, presc_act_d;
   logic                         en_q, en_d;
   logic                         busy_q, busy_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [NUM_CH-1:0]            pwm_q, pwm_d;
   logic                         tick_out_q, tick_out_d;

   logic tick;
   logic at_top;
   logic boundary;
   logic apply;
   logic commit_req;

   assign commit_req = cfg.cfg_we && (cfg.cfg_addr == ADDR_CTRL)
                       && cfg.cfg_data[CTRL_COMMIT_BIT];

   // Staging writes always land, even on an applying boundary; the active
   // copy is loaded from the pre-write (_q) staging values.
   always_comb begin
      duty_stg_d   = duty_stg_q;
      period_stg_d = period_stg_q;
      presc_stg_d  = presc_stg_q;
      en_d         = en_q;
      if (cfg.cfg_we) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_addr == 4'(i)) begin
               duty_stg_d[i] = CNT_W'(cfg.cfg_data);
            end
         end
         if (cfg.cfg_addr == ADDR_PERIOD) begin
            period_stg_d = CNT_W'(cfg.cfg_data);
         end
         if (cfg.cfg_addr == ADDR_PRESC) begin
            presc_stg_d = PRESC_W'(cfg.cfg_data);
         end
         if (cfg.cfg_addr == ADDR_CTRL) begin
            en_d = cfg.cfg_data[CTRL_EN_BIT];
         end
      end
   end

   ppwm_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_q),
      .clr_i   (apply),
      .presc_i (presc_act_q),
      .tick_o  (tick)
   );

   assign at_top   = (cnt_q == period_act_q);
   assign boundary = tick && at_top;
   // While disabled there is no boundary to wait for, so a pending commit
   // lands immediately.
   assign apply    = busy_q && (boundary || !en_q);

   always_comb begin
      duty_act_d   = duty_act_q;
      period_act_d = period_act_q;
      presc_act_d  = presc_act_q;
      if (apply) begin
         duty_act_d   = duty_stg_q;
         period_act_d = period_stg_q;
         presc_act_d  = presc_stg_q;
      end

      cnt_d = cnt_q;
      if (!en_q) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
      end

      // A commit written on the applying cycle is absorbed by that apply.
      busy_d = apply ? 1'b0 : (busy_q || commit_req);

      for (int i = 0; i < NUM_CH; i++) begin
         pwm_d[i] = en_q && (cnt_q < duty_act_q[i]);
      end

      tick_out_d = boundary;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_stg_q   <= '0;
         duty_act_q   <= '0;
         period_stg_q <= CNT_W'(PERIOD_RST);
         period_act_q <= CNT_W'(PERIOD_RST);
         presc_stg_q  <= '0;
         presc_act_q  <= '0;
         en_q         <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
         pwm_q        <= '0;
         tick_out_q   <= 1'b0;
      end else begin
         duty_stg_q   <= duty_stg_d;
         duty_act_q   <= duty_act_d;
         period_stg_q <= period_stg_d;
         period_act_q <= period_act_d;
         presc_stg_q  <= presc_stg_d;
         presc_act_q  <= presc_act_d;
         en_q         <= en_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
         pwm_q        <= pwm_d;
         tick_out_q   <= tick_out_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign period_tick = tick_out_q;
   assign commit_busy = busy_q;

endmodule

// File: tb/tb_ppwm_channel_bank.sv
// Bench for ppwm_channel_bank: table of PWM configurations with expected
// duty/period counts, hand sequences for commit timing, disable and reset,
// then random config traffic checked every cycle against a reference model
// that tracks the elapsed position inside the period.
module tb_ppwm_channel_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] pwm_out;
   logic       period_tick;
   logic       commit_busy;

   int n_vec = 0;
   int n_err = 0;

   ppwm_channel_bank_if cfg_if ();

   ppwm_channel_bank #(
      .NUM_CH  (8),
      .CNT_W   (8),
      .PRESC_W (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg         (cfg_if),
      .pwm_out     (pwm_out),
      .period_tick (period_tick),
      .commit_busy (commit_busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int         m_stg_duty [8];
   int         m_act_duty [8];
   int         m_stg_per, m_act_per, m_stg_pre, m_act_pre;
   bit         m_en, m_busy, m_tick;
   int         m_ph;            // cycles elapsed since the period started
   logic [7:0] m_pwm;

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_stg_duty[i] = 0;
         m_act_duty[i] = 0;
      end
      m_stg_per = 255; m_act_per = 255;
      m_stg_pre = 0;   m_act_pre = 0;
      m_en = 0; m_busy = 0; m_tick = 0; m_ph = 0; m_pwm = '0;
   endtask

   task automatic m_step(input logic rstn, input logic we,
                         input logic [3:0] a, input logic [7:0] d);
      int len, cnt;
      bit bnd, app;
      if (!rstn) begin
         m_reset();
         return;
      end
      len = (m_act_pre + 1) * (m_act_per + 1);
      bnd = m_en && (m_ph == len - 1);
      cnt = m_ph / (m_act_pre + 1);
      for (int i = 0; i < 8; i++) m_pwm[i] = m_en && (cnt < m_act_duty[i]);
      m_tick = bnd;
      app = m_busy && (bnd || !m_en);
      if (app) begin
         for (int i = 0; i < 8; i++) m_act_duty[i] = m_stg_duty[i];
         m_act_per = m_stg_per;
         m_act_pre = m_stg_pre;
         m_busy = 0;
      end
      m_ph = (m_en && !bnd) ? m_ph + 1 : 0;
      if (we) begin
         if (a < 8) m_stg_duty[a] = d;
         else if (a == 8) m_stg_per = d;
         else if (a == 9) m_stg_pre = d;
         else if (a == 10) begin
            if (d[1] && !app) m_busy = 1;
            m_en = d[0];
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      m_step(rst_n, cfg_if.cfg_we, cfg_if.cfg_addr, cfg_if.cfg_data);
      #1;
      n_vec++;
      if (pwm_out !== m_pwm || period_tick !== m_tick || commit_busy !== m_busy) begin
         n_err++;
         $display("FAIL cycle_model @%0t: pwm=%h tick=%b busy=%b expected pwm=%h tick=%b busy=%b",
                  $time, pwm_out, period_tick, commit_busy, m_pwm, m_tick, m_busy);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cfg_if.cfg_we   = 1'b1;
      cfg_if.cfg_addr = a;
      cfg_if.cfg_data = d;
      cyc();
      cfg_if.cfg_we   = 1'b0;
      cfg_if.cfg_addr = '0;
      cfg_if.cfg_data = '0;
   endtask

   task automatic wait_tick(input string nm, input int bound);
      int k;
      k = 0;
      while (period_tick !== 1'b1 && k < bound) begin
         cyc();
         k++;
      end
      n_vec++;
      if (period_tick !== 1'b1) begin
         n_err++;
         $display("FAIL %s: no period_tick within %0d cycles, expected one", nm, bound);
      end
   endtask

   task automatic count_win(input int ch, input int len, output int highs, output int ticks);
      highs = 0;
      ticks = 0;
      for (int k = 0; k < len; k++) begin
         cyc();
         highs += int'(pwm_out[ch]);
         ticks += int'(period_tick);
      end
   endtask

   // Load a configuration with the bank disabled (commit lands next cycle),
   // then enable so the period starts from zero.
   task automatic setup(input int ch, input int pre, input int per, input int duty);
      wr(4'(ch), 8'(duty));
      wr(4'd8, 8'(per));
      wr(4'd9, 8'(pre));
      wr(4'd10, 8'b10);
      cyc();
      chk("setup_commit_applied", int'(commit_busy), 0);
      wr(4'd10, 8'b01);
      cyc();
   endtask

   typedef struct {
      int ch;
      int presc;
      int period;
      int duty;
      int exp_high;
      int exp_len;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int h, t, k, r;
      logic [3:0] ra;
      logic [7:0] rd;

      tbl[0] = '{0, 0, 9,   3,  3, 10};
      tbl[1] = '{1, 1, 3,   2,  4,  8};
      tbl[2] = '{2, 0, 9,   0,  0, 10};
      tbl[3] = '{3, 0, 9, 200, 10, 10};
      tbl[4] = '{4, 0, 0,   1,  1,  1};
      tbl[5] = '{5, 2, 4,   5, 15, 15};
      tbl[6] = '{6, 3, 5,   4, 16, 24};
      tbl[7] = '{7, 0, 9,  10, 10, 10};
      tbl[8] = '{0, 0, 9,   9,  9, 10};

      m_reset();
      rst_n = 1'b0;
      cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
      cyc();
      cyc();
      rst_n = 1'b1;
      chk("reset_pwm", int'(pwm_out), 0);
      chk("reset_tick", int'(period_tick), 0);
      chk("reset_busy", int'(commit_busy), 0);

      // enable+commit together waits for the reset period (256 cycles)
      wr(4'd8, 8'd9);
      wr(4'd0, 8'd3);
      wr(4'd10, 8'b11);
      chk("t1_busy_pending", int'(commit_busy), 1);
      cyc();
      wait_tick("t1_first_boundary", 300);
      chk("t1_busy_cleared", int'(commit_busy), 0);
      count_win(0, 10, h, t);
      chk("t1_high", h, 3);
      chk("t1_ticks", t, 1);

      for (int v = 0; v < 9; v++) begin
         setup(tbl[v].ch, tbl[v].presc, tbl[v].period, tbl[v].duty);
         count_win(tbl[v].ch, tbl[v].exp_len, h, t);
         chk($sformatf("tbl%0d_high", v), h, tbl[v].exp_high);
         chk($sformatf("tbl%0d_ticks", v), t, 1);
      end

      // staged duty without commit has no effect; commit lands at boundary
      setup(0, 0, 9, 3);
      cyc();
      wait_tick("t3_sync", 20);
      repeat (3) cyc();
      wr(4'd0, 8'd7);
      count_win(0, 10, h, t);
      chk("t3_nocommit_high", h, 3);
      cyc();
      wr(4'd10, 8'b11);
      chk("t3_busy_set", int'(commit_busy), 1);
      cyc();
      wait_tick("t3_apply", 20);
      chk("t3_busy_clear_at_tick", int'(commit_busy), 0);
      count_win(0, 10, h, t);
      chk("t3_new_high", h, 7);

      // commit written exactly on a boundary edge waits a full period
      cyc();
      wait_tick("t5_sync", 20);
      wr(4'd0, 8'd5);
      repeat (8) cyc();
      wr(4'd10, 8'b11);
      chk("t5_tick_on_commit", int'(period_tick), 1);
      chk("t5_busy_after_boundary", int'(commit_busy), 1);
      repeat (9) cyc();
      chk("t5_still_busy", int'(commit_busy), 1);
      cyc();
      chk("t5_apply_tick", int'(period_tick), 1);
      chk("t5_apply_busy", int'(commit_busy), 0);
      count_win(0, 10, h, t);
      chk("t5_new_high", h, 5);

      // disable, re-enable from zero
      wr(4'd10, 8'b00);
      cyc();
      chk("t6_disabled_pwm", int'(pwm_out), 0);
      chk("t6_disabled_tick", int'(period_tick), 0);
      wr(4'd10, 8'b01);
      for (int j = 0; j < 10; j++) begin
         cyc();
         chk($sformatf("t6_restart_pwm%0d", j), int'(pwm_out[0]), (j < 5) ? 1 : 0);
         chk($sformatf("t6_restart_tick%0d", j), int'(period_tick), (j == 9) ? 1 : 0);
      end

      // reset mid-period discards a pending commit and restores period 0xFF
      wr(4'd10, 8'b11);
      cyc();
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      chk("t6_rst_pwm", int'(pwm_out), 0);
      chk("t6_rst_tick", int'(period_tick), 0);
      chk("t6_rst_busy", int'(commit_busy), 0);
      wr(4'd10, 8'b01);
      wait_tick("t6_rst_first_tick", 300);
      k = 0;
      cyc();
      k++;
      while (period_tick !== 1'b1 && k < 300) begin
         cyc();
         k++;
      end
      chk("t6_rst_period_len", k, 256);

      // random config traffic against the model
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 199);
         if (r < 3) begin
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
         end else if (r < 50) begin
            ra = 4'($urandom_range(0, 15));
            if (ra == 4'd8 || ra == 4'd9)
               rd = 8'($urandom_range(0, 6));
            else if (ra == 4'd10)
               rd = {6'b0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) != 0)};
            else if ($urandom_range(0, 3) == 0)
               rd = 8'($urandom);
            else
               rd = 8'($urandom_range(0, 8));
            wr(ra, rd);
         end else begin
            cyc();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
